// File: rtl/fp_to_int_conv.sv
// fp_to_int_conv: sequential IEEE 754 binary32 to signed integer converter, one shift bit per cycle.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/a operand handshake;
//        out_valid/out_ready/result/flags {invalid, overflow, inexact} result handshake.
// Config: define FP2INT_RNE_EN for round-to-nearest-even, otherwise truncation toward zero.
module fp_to_int_conv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
    localparam logic [WIDTH-1:0] INT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t           state;
    logic             sign, left, guard, sticky, special, inc, nan;
    logic [4:0]       cnt, cnt_init;
    logic [7:0]       exp;
    logic [22:0]      man;
    logic [WIDTH-1:0] mag, rounded, sp_result, sp_res_c;
    logic [2:0]       sp_flags, sp_flg_c;

    assign exp = a[30:23];
    assign man = a[22:0];
    assign nan = exp == 8'd255 && man != 23'd0;
    assign in_ready = state == IDLE && !reset;
    // Shift distance is |exp - 150|, computed mod 32 since it never exceeds 25.
    assign cnt_init = exp >= 8'd150 ? exp[4:0] - 5'd22 : exp <= 8'd125 ? 5'd25 : 5'd22 - exp[4:0];
    assign sp_res_c = nan ? INT_MAX : exp == 8'd0 ? '0 : a[31] ? INT_MIN : INT_MAX;
    assign sp_flg_c = nan ? 3'b100 : exp == 8'd0 ? {2'b00, |man} : a == 32'hCF000000 ? 3'b000 : 3'b010;
`ifdef FP2INT_RNE_EN
    assign inc = guard & (sticky | mag[0]);
`else
    assign inc = 1'b0;
`endif
    assign rounded = mag + {{(WIDTH-1){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            sign      <= 1'b0;
            left      <= 1'b0;
            special   <= 1'b0;
            mag       <= '0;
            sp_result <= '0;
            sp_flags  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state     <= SHIFT;
                    sign      <= a[31];
                    left      <= exp >= 8'd150;
                    cnt       <= cnt_init;
                    mag       <= {{(WIDTH-24){1'b0}}, 1'b1, man};
                    guard     <= 1'b0;
                    sticky    <= 1'b0;
                    // Exponent 0 and |value| >= 2^31 (incl. inf/NaN) skip the datapath.
                    special   <= exp == 8'd0 || exp >= 8'd158;
                    sp_result <= sp_res_c;
                    sp_flags  <= sp_flg_c;
                end
                SHIFT: if (special) begin
                    state     <= DONE;
                    result    <= sp_result;
                    flags     <= sp_flags;
                    out_valid <= 1'b1;
                end else if (cnt == 5'd0) begin
                    state <= ROUND;
                end else begin
                    cnt <= cnt - 5'd1;
                    if (left) begin
                        mag <= mag << 1;
                    end else begin
                        mag    <= mag >> 1;
                        guard  <= mag[0];
                        sticky <= sticky | guard;
                    end
                end
                ROUND: begin
                    state     <= DONE;
                    result    <= sign ? -rounded : rounded;
                    flags     <= {2'b00, guard | sticky};
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int_conv.sv
// tb_fp_to_int_conv: directed scoreboard bench for fp_to_int_conv.
module tb_fp_to_int_conv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [2:0]  flags;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } exp_t;
    exp_t q[$];

    fp_to_int_conv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

`ifdef FP2INT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Drive one operand, push its expectation, then wait for and score the output.
    task automatic send(input string tag, input logic [31:0] v, input logic [31:0] r,
                        input logic [2:0] f, input int lat);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        a = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        e.r = r;
        e.f = f;
        e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'hDEADBEEF;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        e = q.pop_front();
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_res"}, result, e.r);
        check({tag, "_flg"}, 32'(flags), 32'(e.f));
        if (out_ready) begin
            @(posedge clk);
            #1 check({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
        end
    endtask

    initial begin
        logic [31:0] r0;
        logic [2:0]  f0;
        int n;
        repeat (2) @(posedge clk);
        #1 check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out", {out_valid, result[30:0]}, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_release_ready", 32'(in_ready), 32'd1);

        send("one_five", 32'h3FC00000, RNE ? 32'd2 : 32'd1, 3'b001, 25);
        send("two_five", 32'h40200000, 32'd2, 3'b001, 24);
        send("neg_one", 32'hBF800000, 32'hFFFFFFFF, 3'b000, 25);
        send("neg_two_five", 32'hC0200000, 32'hFFFFFFFE, 3'b001, 24);
        send("one_75", 32'h3FE00000, RNE ? 32'd2 : 32'd1, 3'b001, 25);
        send("half", 32'h3F000000, 32'd0, 3'b001, 26);
        send("quarter", 32'h3E800000, 32'd0, 3'b001, 27);
        send("two_23", 32'h4B000000, 32'h00800000, 3'b000, 2);
        send("max_exact", 32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 9);
        send("int_min", 32'hCF000000, 32'h80000000, 3'b000, 1);
        send("pos_ovf", 32'h4F000000, 32'h7FFFFFFF, 3'b010, 1);
        send("neg_ovf", 32'hCF000001, 32'h80000000, 3'b010, 1);
        send("neg_inf", 32'hFF800000, 32'h80000000, 3'b010, 1);
        send("nan", 32'h7FC00000, 32'h7FFFFFFF, 3'b100, 1);
        send("subnorm", 32'h00000001, 32'd0, 3'b001, 1);
        send("neg_zero", 32'h80000000, 32'd0, 3'b000, 1);

        out_ready = 1'b0;
        send("hold", 32'h40200000, 32'd2, 3'b001, 24);
        r0 = result;
        f0 = flags;
        in_valid = 1'b1;
        a = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("hold_res", result, r0);
            check("hold_state", 32'({out_valid, in_ready, flags == f0}), 32'b101);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("hold_release", 32'({out_valid, in_ready}), 32'b01);

        @(negedge clk);
        a = 32'h3FC00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mid_rst_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("mid_rst_release", 32'(in_ready), 32'd1);
        check("mid_rst_out", {out_valid, result[30:0]}, 32'd0);
        check("mid_rst_flags", 32'(flags), 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (out_valid) n++;
        end
        check("mid_rst_no_pulse", n, 0);
        check("sb_empty", q.size(), 0);

        send("after_rst", 32'h3FC00000, RNE ? 32'd2 : 32'd1, 3'b001, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_to_int_conv.md
FP_TO_INT_CONV -- requirements
Module: fp_to_int_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the IEEE 754 single-precision operand and integer result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand a is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand; high only in IDLE and only while reset is low.
REQ-006 SHALL have port a  input  WIDTH  IEEE 754 binary32 operand: sign [31], exponent [30:23], mantissa [22:0].
REQ-007 SHALL have port out_valid  output  1  result and flags are valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port result  output  WIDTH  signed two's-complement integer.
REQ-010 SHALL have port flags  output  3  {invalid, overflow, inexact}.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, ROUND and DONE.
REQ-012 SHALL register a on the edge where in_valid and in_ready are both high, and SHALL leave IDLE on that edge.
REQ-013 SHALL form significand {1,mantissa} for exponent 1..254, and SHALL treat exponent 0 (zero or subnormal) as magnitude 0 with inexact set when mantissa != 0.
REQ-014 SHALL compute e = exponent - 127.
  - e >= 23: left-shift the significand by e-23.
  - e < 23: right-shift the significand by S = min(23-e, 25).
REQ-015 SHALL perform one shift bit per cycle in SHIFT using a down-counter.
  - On right shifts, the last bit shifted out is the guard bit; all earlier shifted-out bits OR into sticky.
REQ-016 Special cases SHALL bypass SHIFT and ROUND and reach DONE on the edge after acceptance:
  - NaN: result 0x7FFFFFFF, invalid=1.
  - +inf, or e >= 31 with sign=0: result 0x7FFFFFFF, overflow=1.
  - -inf, or e >= 31 with sign=1, except operand 0xCF000000: result 0x80000000, overflow=1.
  - Operand 0xCF000000: result 0x80000000, flags 0.
  - Exponent 0: result 0.
REQ-017 Normal-case latency: out_valid SHALL rise S+2 edges after the acceptance edge, where S is the shift count (0..25).
REQ-018 ROUND SHALL apply the rounding rule of REQ-029, negate when sign=1, set inexact = guard | sticky, and enter DONE.
REQ-019 In DONE, out_valid SHALL be high, and result and flags SHALL be held stable until out_ready is high.
REQ-020 DONE SHALL return to IDLE on the edge where out_ready is high; in_ready SHALL stay low during DONE, so a new operand cannot be accepted in the same cycle as result delivery.
REQ-021 Inputs a and in_valid SHALL be ignored outside IDLE.
REQ-022 Rounding SHALL never overflow the integer range, since e <= 30 implies an exact left shift.

Reset
REQ-023 While reset is high on a clk edge, the FSM SHALL enter IDLE.
REQ-024 After reset: result=0, flags=0, out_valid=0, shift counter=0, and guard and sticky cleared.
REQ-025 Reset asserted in SHIFT, ROUND or DONE SHALL discard the operation in progress; no out_valid pulse SHALL follow.
REQ-026 in_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL use preprocessor macro FP2INT_RNE_EN to select the rounding mode.
REQ-028 Without FP2INT_RNE_EN, rounding SHALL truncate toward zero: magnitude unchanged; inexact still reported.
REQ-029 With FP2INT_RNE_EN, rounding SHALL be round-to-nearest-even: magnitude incremented when guard & (sticky | lsb).

Verification
REQ-030 Bench SHALL cover: a=0x3FC00000 (1.5), out_ready=1 -> result 2 with RNE (1 truncated), flags 001, out_valid 25 edges after acceptance.
REQ-031 Bench SHALL cover: a=0x40200000 (2.5) -> result 2 in both modes, flags 001; and a=0xBF800000 (-1.0) -> result 0xFFFFFFFF, flags 000.
REQ-032 Bench SHALL cover: a=0xCF000000 -> 0x80000000 with flags 000; a=0x4F000000 -> 0x7FFFFFFF with flags 010; each with out_valid 1 edge after acceptance.
REQ-033 Bench SHALL cover: a=0x7FC00000 -> 0x7FFFFFFF, flags 100; and a=0x00000001 -> result 0, flags 001.
REQ-034 Bench SHALL cover: out_ready held low 5 cycles in DONE -> result and flags stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-035 Bench SHALL cover: reset pulsed during SHIFT for a=0x3FC00000 -> out_valid stays 0, outputs 0, in_ready=1 the cycle after reset deasserts.
